secded_stream_link: RTL and testbench
=====================================

Name: secded_stream_link

Overview:
- Parametrised, pipelined successor to the combinational encoder/channel/decoder chain.
- Encodes a streaming data word with SEC-DED check bits, optionally injects 0/1/2 bit flips per beat, then decodes and corrects the word.
- Carries valid/ready flow control, per-beat error flags, saturating SEC/DED counters and a first-error log.
- Used as the on-chip ECC link model and as the formal/sim harness for wider ECC datapaths.

Parameters:
- DATA_W, 32: data width; legal range 8..64.
- ECC_W, derived (localparam): Hamming bits p, the smallest value with 2^p >= DATA_W+p+1, plus 1 overall parity bit. DATA_W=32 gives 7.
- CW, derived (localparam): DATA_W+ECC_W, the codeword width (39 at default).
- POS_W, derived (localparam): clog2(CW), the position field width.
- CNT_W, 16: error counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  payload
inj_mode  in  2  0 none, 1 single flip, 2 double flip, 3 reserved (treated as 0)
inj_pos1  in  POS_W  first flip position in codeword
inj_pos2  in  POS_W  second flip position
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  corrected data
out_ecc  out  ECC_W  corrected check bits
out_single  out  1  beat had a corrected single error
out_double  out  1  beat had an uncorrectable double error
sec_count  out  CNT_W  saturating count of single-error beats delivered
ded_count  out  CNT_W  saturating count of double-error beats delivered
cnt_clear  in  1  synchronous clear of counters and log
log_valid  out  1  first-error log holds an entry
log_double  out  1  logged error was a double
log_syndrome  out  ECC_W  syndrome of the logged beat

Behaviour:
- Codeword layout is {ecc, data}. Bit indices 0..DATA_W-1 are data; DATA_W..CW-1 are ecc. ecc[ECC_W-1] is overall parity over all other CW-1 bits.
- For DATA_W=32, check-bit equations match rvecc_encode bit-for-bit.
- Three register stages: S0 encode, S1 inject, S2 decode/output.
- inj_* are sampled with in_data on acceptance and travel with the beat.
- Latency is exactly 3 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stage n advances when it is empty or stage n+1 advances. S2 advances on out_ready.
- in_ready = !S0.valid || S0 advances. This is combinational and carries no combinational path from in_valid.
- out_* are held stable while out_valid && !out_ready.
- Injection rules:
  - A position >= CW flips nothing.
  - Mode 2 with pos1 == pos2 flips nothing.
  - Mode 2 with one position out of range becomes a single flip.
- Decode rules (syndrome s, overall-parity mismatch m):
  - s=0, m=0: clean.
  - s!=0, m=1: single; flip the indicated bit; out_single=1.
  - s=0, m=1: single in the parity bit; corrected; out_single=1.
  - s!=0, m=0: double; data passed uncorrected; out_double=1.
  - A syndrome pointing beyond CW-1 with m=1 is reported as double.
- out_single and out_double are never both 1.
- Counters increment only on an output transfer (out_valid && out_ready) with the matching flag. They saturate at all-ones.
- cnt_clear zeroes both counters and log_valid. It has priority over a same-cycle increment or log capture, and that event is lost.
- Log capture happens on the first flagged output transfer while log_valid=0: log_valid=1, log_double=out_double, log_syndrome=s. The entry is held until cnt_clear or rst.
- Reset values:
  - All stage valids, out_valid, out_single, out_double, counters, log_valid, log_double and log_syndrome are 0.
  - out_data and out_ecc are 0.
  - in_ready=0 while rst is high and 1 in the first cycle after release.
- Reset asserted mid-flight discards all in-flight beats; no partial output appears.

Test Plan:
- Clean stream: in_data=0x00000000 then 0xA5A5A5A5, inj_mode=0 -> outputs at cycle +3 with identical data, out_ecc=0 for the zero word, no flags, counters 0.
- Single flip: 0xA5A5A5A5, mode 1, pos1=5; then mode 1, pos1=38 -> out_data=0xA5A5A5A5 and encoder ecc restored both times, out_single=1, sec_count=2, log_valid=1, log_double=0.
- Double flip: mode 2, pos 0 and 38 -> out_double=1, out_single=0, ded_count=1. Mode 2 with pos 7 and 7 -> clean beat.
- Backpressure: 6 back-to-back beats with out_ready=0 for 5 cycles -> exactly 3 beats accepted, in_ready=0, out_data stable. On release, all 6 are delivered in order with no loss or duplication.
- Saturation and clear (CNT_W=2): 5 single-error beats -> sec_count=3. cnt_clear coincident with a 6th flagged transfer -> sec_count=0, log_valid=0.
- Reset mid-flight: rst asserted with 3 beats in the pipe -> out_valid=0 immediately, and no old beat appears after release.

Source files
------------

// File: rtl/secded_stream_link.sv
// secded_stream_link: three-stage SEC-DED encode / inject / decode link
// with valid/ready flow control, saturating error counters and error log.
module secded_stream_link #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int P     = (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 :
                         (DATA_W <= 57) ? 6 : 7,
  localparam int ECC_W = P + 1,
  localparam int CW    = DATA_W + ECC_W,
  localparam int POS_W = $clog2(CW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        inj_mode,
  input  logic [POS_W-1:0]  inj_pos1,
  input  logic [POS_W-1:0]  inj_pos2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ECC_W-1:0]  out_ecc,
  output logic              out_single,
  output logic              out_double,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  input  logic              cnt_clear,
  output logic              log_valid,
  output logic              log_double,
  output logic [ECC_W-1:0]  log_syndrome
);

  // Hamming position (1-based, powers of two skipped) of data bit k
  function automatic int hpos(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) res = p;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  function automatic logic [P-1:0] hcheck(
    input logic [DATA_W-1:0] d
  );
    logic [P-1:0] c;
    c = '0;
    for (int i = 0; i < P; i++)
      for (int k = 0; k < DATA_W; k++)
        if (((hpos(k) >> i) & 1) != 0)
          c[i] = c[i] ^ d[k];
    return c;
  endfunction

  // One-hot flip mask; out-of-range positions give no bit
  function automatic logic [CW-1:0] bit_at(
    input logic [POS_W-1:0] p
  );
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < CW; i++)
      if (int'(p) == i) m[i] = 1'b1;
    return m;
  endfunction

  logic              v0_q, v1_q, v2_q;
  logic [CW-1:0]     cw0_q, cw1_q;
  logic [1:0]        mode0_q;
  logic [POS_W-1:0]  pa0_q, pb0_q;
  logic [DATA_W-1:0] dat_q;
  logic [ECC_W-1:0]  ecc_q, syn_q;
  logic              sgl_q, dbl_q;
  logic              adv0, adv1, adv2, acc, xfer;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign adv0     = !v0_q || adv1;
  assign in_ready = !rst && adv0;
  assign acc      = in_valid && in_ready;
  assign xfer     = v2_q && out_ready;

  logic [P-1:0]  enc_c;
  logic [CW-1:0] enc_cw;
  assign enc_c  = hcheck(in_data);
  assign enc_cw = {^{in_data, enc_c}, enc_c, in_data};

  // Flip mask for the beat sitting in S0; equal positions cancel
  logic [CW-1:0] inj_mask;
  always_comb begin
    inj_mask = '0;
    case (mode0_q)
      2'd1:    inj_mask = bit_at(pa0_q);
      2'd2:    inj_mask = bit_at(pa0_q) ^ bit_at(pb0_q);
      default: inj_mask = '0;
    endcase
  end

  logic [P-1:0]  syn;
  logic          mis, hit, dec_sgl, dec_dbl;
  logic [CW-1:0] fix, corr;
  assign syn  = hcheck(cw1_q[DATA_W-1:0]) ^ cw1_q[DATA_W +: P];
  assign mis  = ^cw1_q;
  assign corr = cw1_q ^ fix;

  // Locate the flipped bit from the syndrome and classify the beat
  always_comb begin
    fix = '0;
    hit = 1'b0;
    for (int i = 0; i < P; i++)
      if (int'(syn) == (1 << i)) begin
        fix[DATA_W+i] = 1'b1;
        hit = 1'b1;
      end
    for (int k = 0; k < DATA_W; k++)
      if (int'(syn) == hpos(k)) begin
        fix[k] = 1'b1;
        hit = 1'b1;
      end
    dec_sgl = 1'b0;
    dec_dbl = 1'b0;
    if (mis && syn == '0) begin
      fix[CW-1] = 1'b1;
      dec_sgl = 1'b1;
    end else if (mis && hit) begin
      dec_sgl = 1'b1;
    end else if (syn != '0) begin
      fix = '0;
      dec_dbl = 1'b1;
    end
  end

  // Three-stage pipeline with per-stage stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0;
      cw0_q <= '0; cw1_q <= '0; mode0_q <= '0;
      pa0_q <= '0; pb0_q <= '0;
      dat_q <= '0; ecc_q <= '0; syn_q <= '0;
      sgl_q <= 1'b0; dbl_q <= 1'b0;
    end else begin
      if (adv0) begin
        v0_q <= acc;
        if (acc) begin
          cw0_q   <= enc_cw;
          mode0_q <= inj_mode;
          pa0_q   <= inj_pos1;
          pb0_q   <= inj_pos2;
        end
      end
      if (adv1) begin
        v1_q <= v0_q;
        if (v0_q) cw1_q <= cw0_q ^ inj_mask;
      end
      if (adv2) begin
        v2_q  <= v1_q;
        sgl_q <= v1_q && dec_sgl;
        dbl_q <= v1_q && dec_dbl;
        if (v1_q) begin
          dat_q <= corr[DATA_W-1:0];
          ecc_q <= corr[CW-1:DATA_W];
          syn_q <= {mis, syn};
        end
      end
    end
  end

  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;
  logic             lv_q, lv_d, ld_q, ld_d;
  logic [ECC_W-1:0] ls_q, ls_d;

  // Counter and log next state; clear beats a same-cycle event
  always_comb begin
    sec_d = sec_q;
    ded_d = ded_q;
    lv_d  = lv_q;
    ld_d  = ld_q;
    ls_d  = ls_q;
    if (cnt_clear) begin
      sec_d = '0;
      ded_d = '0;
      lv_d  = 1'b0;
    end else if (xfer) begin
      if (sgl_q && sec_q != '1) sec_d = sec_q + CNT_W'(1);
      if (dbl_q && ded_q != '1) ded_d = ded_q + CNT_W'(1);
      if ((sgl_q || dbl_q) && !lv_q) begin
        lv_d = 1'b1;
        ld_d = dbl_q;
        ls_d = syn_q;
      end
    end
  end

  // Counter and log registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= '0; ded_q <= '0;
      lv_q <= 1'b0; ld_q <= 1'b0; ls_q <= '0;
    end else begin
      sec_q <= sec_d; ded_q <= ded_d;
      lv_q <= lv_d; ld_q <= ld_d; ls_q <= ls_d;
    end
  end

  assign out_valid    = v2_q;
  assign out_data     = dat_q;
  assign out_ecc      = ecc_q;
  assign out_single   = sgl_q;
  assign out_double   = dbl_q;
  assign sec_count    = sec_q;
  assign ded_count    = ded_q;
  assign log_valid    = lv_q;
  assign log_double   = ld_q;
  assign log_syndrome = ls_q;

endmodule

// File: tb/tb_secded_stream_link.sv
// tb_secded_stream_link: directed bench for secded_stream_link
// (default instance plus a CNT_W=2 instance for saturation).
module tb_secded_stream_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  inj_mode;
  logic [5:0]  inj_pos1, inj_pos2;
  logic [6:0]  out_ecc, log_syndrome;
  logic        out_single, out_double, cnt_clear;
  logic [15:0] sec_count, ded_count;
  logic        log_valid, log_double;

  logic        s_in_valid, s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [6:0]  s_out_ecc, s_log_syn;
  logic        s_single, s_double, s_clear;
  logic [1:0]  s_sec, s_ded;
  logic        s_log_valid, s_log_double;

  secded_stream_link u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_mode(inj_mode),
    .inj_pos1(inj_pos1), .inj_pos2(inj_pos2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ecc(out_ecc),
    .out_single(out_single), .out_double(out_double),
    .sec_count(sec_count), .ded_count(ded_count),
    .cnt_clear(cnt_clear), .log_valid(log_valid),
    .log_double(log_double), .log_syndrome(log_syndrome)
  );

  secded_stream_link #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(32'h12345678), .inj_mode(2'd1),
    .inj_pos1(6'd5), .inj_pos2(6'd0),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_data(s_out_data), .out_ecc(s_out_ecc),
    .out_single(s_single), .out_double(s_double),
    .sec_count(s_sec), .ded_count(s_ded),
    .cnt_clear(s_clear), .log_valid(s_log_valid),
    .log_double(s_log_double), .log_syndrome(s_log_syn)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag,
                      input logic [31:0] d,
                      input logic [1:0] m,
                      input logic [5:0] a,
                      input logic [5:0] b,
                      input logic [31:0] xd,
                      input logic [6:0] xe,
                      input logic xs,
                      input logic xdb);
    in_valid = 1'b1;
    in_data  = d;
    inj_mode = m;
    inj_pos1 = a;
    inj_pos2 = b;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, ".early"}, out_valid, 0);
    tick();
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".data"}, out_data, xd);
    chk({tag, ".ecc"}, out_ecc, xe);
    chk({tag, ".sgl"}, out_single, xs);
    chk({tag, ".dbl"}, out_double, xdb);
    tick();
  endtask

  logic [31:0] dv [6] = '{32'h0BAD0001, 32'h0BAD0002,
                          32'h0BAD0003, 32'h0BAD0004,
                          32'h0BAD0005, 32'h0BAD0006};

  initial begin
    int idx;
    int nrx;
    int seen;
    logic take;
    logic got;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    inj_mode = '0;
    inj_pos1 = '0;
    inj_pos2 = '0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    s_in_valid = 1'b0;
    s_clear = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_ecc", out_ecc, 0);
    chk("rst.flags", {out_single, out_double}, 0);
    chk("rst.counts", {sec_count, ded_count}, 0);
    chk("rst.log", {log_valid, log_double, log_syndrome}, 0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", in_ready, 1);

    beat("clean0", 32'h0, 2'd0, 6'd0, 6'd0,
         32'h0, 7'h00, 1'b0, 1'b0);
    beat("cleanA5", 32'hA5A5A5A5, 2'd0, 6'd0, 6'd0,
         32'hA5A5A5A5, 7'h72, 1'b0, 1'b0);
    chk("clean.counts", {sec_count, ded_count}, 0);
    chk("clean.log", log_valid, 0);

    beat("sgl5", 32'hA5A5A5A5, 2'd1, 6'd5, 6'd0,
         32'hA5A5A5A5, 7'h72, 1'b1, 1'b0);
    beat("sgl38", 32'hA5A5A5A5, 2'd1, 6'd38, 6'd0,
         32'hA5A5A5A5, 7'h72, 1'b1, 1'b0);
    chk("sgl.sec", sec_count, 2);
    chk("sgl.log_valid", log_valid, 1);
    chk("sgl.log_double", log_double, 0);
    chk("sgl.log_syn", log_syndrome, 7'h4A);

    beat("dbl0_38", 32'hA5A5A5A5, 2'd2, 6'd0, 6'd38,
         32'hA5A5A5A4, 7'h32, 1'b0, 1'b1);
    chk("dbl.ded", ded_count, 1);
    chk("dbl.sec", sec_count, 2);
    chk("dbl.log_kept", {log_double, log_syndrome}, 8'h4A);
    beat("dbl7_7", 32'hA5A5A5A5, 2'd2, 6'd7, 6'd7,
         32'hA5A5A5A5, 7'h72, 1'b0, 1'b0);
    beat("dbl3_60", 32'hA5A5A5A5, 2'd2, 6'd3, 6'd60,
         32'hA5A5A5A5, 7'h72, 1'b1, 1'b0);
    beat("sgl63", 32'hA5A5A5A5, 2'd1, 6'd63, 6'd0,
         32'hA5A5A5A5, 7'h72, 1'b0, 1'b0);
    beat("mode3", 32'hA5A5A5A5, 2'd3, 6'd5, 6'd9,
         32'hA5A5A5A5, 7'h72, 1'b0, 1'b0);
    chk("end.sec", sec_count, 3);
    chk("end.ded", ded_count, 1);

    idx = 0;
    nrx = 0;
    inj_mode = 2'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (idx < 6);
      in_data = dv[(idx < 6) ? idx : 0];
      #1;
      if (cyc == 3 || cyc == 4) begin
        chk("bp.in_ready", in_ready, 0);
        chk("bp.hold_v", out_valid, 1);
        chk("bp.hold_d", out_data, dv[0]);
      end
      if (cyc == 5) chk("bp.accepted", idx, 3);
      if (out_valid && out_ready) begin
        if (nrx < 6) chk("bp.order", out_data, dv[nrx]);
        else chk("bp.dup", nrx, 5);
        nrx++;
      end
      take = in_valid && in_ready;
      tick();
      if (take) idx++;
    end
    in_valid = 1'b0;
    chk("bp.count", nrx, 6);
    out_ready = 1'b1;

    s_in_valid = 1'b1;
    repeat (5) tick();
    s_in_valid = 1'b0;
    repeat (5) tick();
    chk("sat.sec", s_sec, 3);
    chk("sat.ded", s_ded, 0);
    chk("sat.log", s_log_valid, 1);
    chk("sat.data", s_out_data, 32'h12345678);
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      if (s_out_valid) got = 1'b1;
      else tick();
    end
    chk("sat.wait", got, 1);
    chk("sat.flag", s_single, 1);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    chk("clr.sec", s_sec, 0);
    chk("clr.log", s_log_valid, 0);
    chk("clr.gone", s_out_valid, 0);

    in_valid = 1'b1;
    in_data = 32'hDEAD0000;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("mid.pre", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid.out_valid", out_valid, 0);
    chk("mid.in_ready", in_ready, 0);
    chk("mid.counts", {sec_count, ded_count}, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) seen++;
      tick();
    end
    chk("mid.no_ghost", seen, 0);
    chk("mid.ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
